// File: rtl/pulse_mon_pkg.sv
// Purpose  : shared types and default constants for the pulse width monitor.
// Latency  : n/a (types only).
// Backpres.: n/a.
// Contents : FSM state enum, per-record flag struct, default parameter values.
package pulse_mon_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int MIN_W_DEF = 4;
    localparam int SYNC_DEF  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_e;

    // Packages cannot take parameters, so the CNT_W-wide width field is
    // added next to these flags where CNT_W is known (pulse_width_monitor).
    typedef struct packed {
        logic is_short;
        logic sat;
    } rec_flags_t;

endpackage

// File: rtl/sync_bit.sv
// Purpose  : STAGES-flop synchronizer for one asynchronous bit.
// Latency  : STAGES clk cycles from d to q.
// Backpres.: none; free-running.
// Ports    : clk, rst (async active-high), d (async input), q (synchronized).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_width_monitor.sv
// Purpose  : measures the width of each high pulse on sig_in, flags short ones, keeps stats.
// Latency  : record valid SYNC_STAGES+1 edges after the first low sample of sig_in.
// Backpres.: one-entry holding register; a record arriving while it is full is dropped and counted.
// Ports    : clk, rst (async active-high), sig_in (async), en, clr (sync clear),
//            meas_valid/meas_ready/meas_width/meas_short/meas_sat (record interface),
//            pulse_cnt, short_cnt, drop_cnt (saturating stats), ovf (sticky drop flag).
module pulse_width_monitor
    import pulse_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_W       = MIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    input  logic             clr,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_short,
    output logic             meas_sat,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [CNT_W-1:0] short_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf
);

    typedef struct packed {
        logic [CNT_W-1:0] width;
        rec_flags_t       flags;
    } rec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_THR = CNT_W'(MIN_W);

    logic             s;
    logic             s_d;
    state_e           state;
    logic [CNT_W-1:0] width;
    logic             sat;
    logic             rise;
    logic             done;
    logic             accept;
    logic             load;
    logic             drop;
    logic             cur_short;
    rec_t             held;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .q   (s)
    );

    // s_d belongs with the synchronizer: clr leaves it alone so that a level
    // already high when clr drops is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise      = en & s & ~s_d;
    // Completion needs en: with en low the pulse is aborted instead.
    assign done      = (state == HIGH) & en & ~s;
    assign accept    = meas_valid & meas_ready;
    assign load      = done & (~meas_valid | meas_ready);
    assign drop      = done & meas_valid & ~meas_ready;
    assign cur_short = width < MIN_THR;

    // Pulse FSM and width counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            width <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            width <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        width <= CNT_ONE;
                        sat   <= 1'b0;
                    end
                end
                HIGH: begin
                    if (!en || !s) begin
                        state <= IDLE;
                    end else if (width == CNT_MAX) begin
                        sat <= 1'b1;
                    end else begin
                        width <= width + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry holding register. An accept and a new load on the same edge
    // simply replace the contents and keep valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_valid <= 1'b0;
            held       <= '0;
        end else if (clr) begin
            meas_valid <= 1'b0;
            held       <= '0;
        end else if (load) begin
            meas_valid          <= 1'b1;
            held.width          <= width;
            held.flags.is_short <= cur_short;
            held.flags.sat      <= sat;
        end else if (accept) begin
            meas_valid <= 1'b0;
        end
    end

    assign meas_width = held.width;
    assign meas_short = held.flags.is_short;
    assign meas_sat   = held.flags.sat;

    // Statistics; all saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
            short_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            pulse_cnt <= '0;
            short_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (done) begin
                if (pulse_cnt != CNT_MAX) begin
                    pulse_cnt <= pulse_cnt + CNT_ONE;
                end
                if (cur_short && (short_cnt != CNT_MAX)) begin
                    short_cnt <= short_cnt + CNT_ONE;
                end
            end
            if (drop) begin
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + CNT_ONE;
                end
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Purpose  : self-checking bench for pulse_width_monitor (CNT_W=16 and CNT_W=4 instances).
// Latency  : n/a.
// Backpres.: drives meas_ready directly, including long stalls.
module tb_pulse_width_monitor;

    localparam int SYNC  = 2;
    localparam int MIN_W = 4;

    logic clk;
    logic rst;
    logic sig_in;
    logic en;
    logic clr;
    logic ready;

    logic        v0, sh0, st0, ovf0;
    logic [15:0] w0, pc0, sc0, dc0;
    logic        v1, sh1, st1, ovf1;
    logic [3:0]  w1, pc1, sc1, dc1;

    pulse_width_monitor #(.CNT_W(16), .MIN_W(MIN_W), .SYNC_STAGES(SYNC)) u_dut0 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .clr(clr),
        .meas_ready(ready), .meas_valid(v0), .meas_width(w0), .meas_short(sh0),
        .meas_sat(st0), .pulse_cnt(pc0), .short_cnt(sc0), .drop_cnt(dc0), .ovf(ovf0)
    );

    pulse_width_monitor #(.CNT_W(4), .MIN_W(MIN_W), .SYNC_STAGES(SYNC)) u_dut1 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .clr(clr),
        .meas_ready(ready), .meas_valid(v1), .meas_width(w1), .meas_short(sh1),
        .meas_sat(st1), .pulse_cnt(pc1), .short_cnt(sc1), .drop_cnt(dc1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Pulse width is kept as an unbounded run length; the saturated width and
    // the sat flag are derived arithmetically from it at completion.
    int mx [2] = '{65535, 15};
    bit sh_hist [SYNC];
    bit m_sd;
    bit m_act [2];
    int m_run [2];
    bit m_vld [2];
    int m_w   [2];
    bit m_sh  [2];
    bit m_sat [2];
    int m_pc  [2];
    int m_sc  [2];
    int m_dc  [2];
    bit m_ovf [2];

    function automatic int sat_inc(int v, int m);
        return (v >= m) ? m : v + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) sh_hist[k] = 1'b0;
        m_sd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_run[i] = 0; m_vld[i] = 0; m_w[i] = 0;
            m_sh[i] = 0; m_sat[i] = 0; m_pc[i] = 0; m_sc[i] = 0;
            m_dc[i] = 0; m_ovf[i] = 0;
        end
    endtask

    task automatic model_step();
        bit s;
        bit done;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        s = sh_hist[SYNC-1];
        for (int i = 0; i < 2; i++) begin
            done = 1'b0;
            if (clr) begin
                m_act[i] = 0; m_vld[i] = 0; m_pc[i] = 0; m_sc[i] = 0;
                m_dc[i] = 0; m_ovf[i] = 0;
            end else begin
                if (m_act[i]) begin
                    if (!en) m_act[i] = 0;
                    else if (s) m_run[i] = m_run[i] + 1;
                    else begin done = 1'b1; m_act[i] = 0; end
                end else if (en && s && !m_sd) begin
                    m_act[i] = 1;
                    m_run[i] = 1;
                end
                if (done) begin
                    w = (m_run[i] > mx[i]) ? mx[i] : m_run[i];
                    m_pc[i] = sat_inc(m_pc[i], mx[i]);
                    if (w < MIN_W) m_sc[i] = sat_inc(m_sc[i], mx[i]);
                    if (!m_vld[i] || ready) begin
                        m_vld[i] = 1; m_w[i] = w; m_sh[i] = (w < MIN_W);
                        m_sat[i] = (m_run[i] > mx[i]);
                    end else begin
                        m_dc[i] = sat_inc(m_dc[i], mx[i]);
                        m_ovf[i] = 1;
                    end
                end else if (m_vld[i] && ready) begin
                    m_vld[i] = 0;
                end
            end
        end
        m_sd = s;
        for (int k = SYNC - 1; k > 0; k--) sh_hist[k] = sh_hist[k-1];
        sh_hist[0] = sig_in;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] pack(logic v, logic [15:0] w, logic s, logic t,
                                         logic [15:0] pc, logic [15:0] sc,
                                         logic [15:0] dc, logic o);
        return {12'h0, v, (v ? w : 16'h0), v & s, v & t, pc, sc, dc, o};
    endfunction

    task automatic compare_all();
        check("model0", pack(v0, w0, sh0, st0, pc0, sc0, dc0, ovf0),
              pack(m_vld[0], 16'(m_w[0]), m_sh[0], m_sat[0], 16'(m_pc[0]),
                   16'(m_sc[0]), 16'(m_dc[0]), m_ovf[0]));
        check("model1", pack(v1, {12'h0, w1}, sh1, st1, {12'h0, pc1}, {12'h0, sc1},
                             {12'h0, dc1}, ovf1),
              pack(m_vld[1], 16'(m_w[1]), m_sh[1], m_sat[1], 16'(m_pc[1]),
                   16'(m_sc[1]), 16'(m_dc[1]), m_ovf[1]));
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(int len);
        sig_in = 1'b1;
        repeat (len) cyc();
        sig_in = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    // Called right after sig_in drops (ready=1): record must appear exactly
    // after the third edge and be gone after the fourth.
    task automatic expect_rec(string nm, int ew0, bit es0, bit et0,
                              int ew1, bit es1, bit et1);
        cyc();
        cyc();
        check({nm, "_early"}, {78'h0, v1, v0}, 80'h0);
        cyc();
        check({nm, "_valid"}, {78'h0, v1, v0}, 80'h3);
        check({nm, "_rec0"}, {62'h0, w0, sh0, st0}, {62'h0, 16'(ew0), es0, et0});
        check({nm, "_rec1"}, {74'h0, w1, sh1, st1}, {74'h0, 4'(ew1), es1, et1});
        cyc();
        check({nm, "_gone"}, {78'h0, v1, v0}, 80'h0);
    endtask

    typedef struct {
        int len;
        int ew0; bit es0; bit et0;
        int ew1; bit es1; bit et1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{10, 10, 1'b0, 1'b0, 10, 1'b0, 1'b0};
        tbl[1] = '{ 2,  2, 1'b1, 1'b0,  2, 1'b1, 1'b0};
        tbl[2] = '{ 1,  1, 1'b1, 1'b0,  1, 1'b1, 1'b0};
        tbl[3] = '{ 4,  4, 1'b0, 1'b0,  4, 1'b0, 1'b0};
        tbl[4] = '{15, 15, 1'b0, 1'b0, 15, 1'b0, 1'b0};
        tbl[5] = '{16, 16, 1'b0, 1'b0, 15, 1'b0, 1'b1};
        tbl[6] = '{20, 20, 1'b0, 1'b0, 15, 1'b0, 1'b1};

        rst = 1'b1; sig_in = 1'b0; en = 1'b1; clr = 1'b0; ready = 1'b1;
        model_reset();
        cyc();
        cyc();
        check("reset_out0", pack(v0, w0, sh0, st0, pc0, sc0, dc0, ovf0), 80'h0);
        check("reset_out1", {62'h0, v1, w1, sh1, st1, pc1, sc1, dc1, ovf1}, 80'h0);
        rst = 1'b0;
        cyc();

        // Table of single pulses, each from cleared statistics.
        foreach (tbl[n]) begin
            do_clr();
            cyc();
            pulse(tbl[n].len);
            expect_rec($sformatf("tbl%0d", n), tbl[n].ew0, tbl[n].es0, tbl[n].et0,
                       tbl[n].ew1, tbl[n].es1, tbl[n].et1);
            check($sformatf("tbl%0d_cnt0", n), {48'h0, pc0, sc0}, {48'h0, 16'd1, 16'(tbl[n].es0)});
            check($sformatf("tbl%0d_cnt1", n), {72'h0, pc1, sc1}, {72'h0, 4'd1, 4'(tbl[n].es1)});
        end

        // Back-pressure: first record held, two dropped.
        do_clr();
        ready = 1'b0;
        pulse(5); repeat (3) cyc();
        pulse(6); repeat (3) cyc();
        pulse(7); repeat (3) cyc();
        check("bp_hold0", {46'h0, v0, w0, pc0, dc0, ovf0}, {46'h0, 1'b1, 16'd5, 16'd3, 16'd2, 1'b1});
        check("bp_hold1", {66'h0, v1, w1, pc1, dc1, ovf1}, {66'h0, 1'b1, 4'd5, 4'd3, 4'd2, 1'b1});
        ready = 1'b1;
        cyc();
        check("bp_accept", {76'h0, v1, v0, ovf1, ovf0}, {76'h0, 4'b0011});

        // en dropped mid-pulse: aborted, nothing counted.
        do_clr();
        sig_in = 1'b1;
        repeat (4) cyc();
        en = 1'b0;
        cyc();
        sig_in = 1'b0;
        repeat (4) cyc();
        en = 1'b1;
        check("abort", {62'h0, v0, pc0, v1, w1[0]}, 80'h0);

        // en rising while the input is already high: that pulse is ignored.
        en = 1'b0;
        sig_in = 1'b1;
        repeat (4) cyc();
        en = 1'b1;
        repeat (3) cyc();
        sig_in = 1'b0;
        repeat (4) cyc();
        check("late_en", {63'h0, v0, pc0}, 80'h0);
        pulse(3);
        expect_rec("after_late_en", 3, 1'b1, 1'b0, 3, 1'b1, 1'b0);

        // clr on the completion edge discards the record and zeroes stats.
        do_clr();
        pulse(4);
        cyc();
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clr_done", {46'h0, v0, pc0, sc0, ovf0, v1}, 80'h0);
        cyc();
        check("clr_after", {78'h0, v1, v0}, 80'h0);

        // Asynchronous reset in the middle of a pulse with a record held.
        ready = 1'b0;
        pulse(3);
        repeat (3) cyc();
        check("pre_rst", {63'h0, v0, pc0}, {63'h0, 1'b1, 16'd1});
        sig_in = 1'b1;
        repeat (5) cyc();
        rst = 1'b1;
        #1;
        check("async_rst0", pack(v0, w0, sh0, st0, pc0, sc0, dc0, ovf0), 80'h0);
        check("async_rst1", {62'h0, v1, w1, sh1, st1, pc1, sc1, dc1, ovf1}, 80'h0);
        model_reset();
        sig_in = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        ready = 1'b1;
        cyc();

        // Randomized traffic against the model; second half favours long pulses.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, (c < 2000) ? 3 : 12) == 0) sig_in = ~sig_in;
            en    = ($urandom_range(0, 29) != 0);
            ready = ($urandom_range(0, 2) != 0);
            clr   = ($urandom_range(0, 299) == 0);
            cyc();
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
